// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and helpers for the VGA output path.
//   mode_e        : frame-latched colour source selection
//   BRIGHT_UNITY  : brightness code that leaves colour unchanged
//   expand_bits() : MSB-first bit replication from in_w to out_w bits
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRAY  = 2'd2,
    MODE_BLACK = 2'd3
  } mode_e;

  localparam logic [3:0] BRIGHT_UNITY = 4'd15;

  // Widest channel widths the helpers support.
  localparam int MAX_IN_W  = 8;
  localparam int MAX_OUT_W = 10;

  // Replicates the in_w-bit value (right-aligned in 'value') MSB-first until
  // out_w bits are filled, dropping whatever does not fit. The result is
  // right-aligned. All-ones stays all-ones and zero stays zero.
  // Example: in_w=3, out_w=8, value=3'b011 -> 8'b011_011_01.
  function automatic logic [MAX_OUT_W-1:0] expand_bits(
    input logic [MAX_IN_W-1:0] value,
    input int                  in_w,
    input int                  out_w
  );
    logic [MAX_OUT_W-1:0] result;
    result = '0;
    for (int j = 0; j < MAX_OUT_W; j++) begin
      if (j < out_w) begin
        result[4'(out_w - 1 - j)] = value[3'(in_w - 1 - (j % in_w))];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// -----------------------------------------------------------------------------
// vga_bar_counter
// Tracks which test-pattern bar the pixel currently in stage 1 belongs to.
// The first visible pixel of a line is column 0; every H_ACTIVE/BAR_COUNT
// visible pixels the bar index advances, saturating at the last bar. Any
// cycle with video_on low clears the position.
// Ports:
//   clk, rst  : pixel clock, asynchronous active-high reset
//   video_on  : visible-area flag for the pixel being registered this edge
//   bar_idx   : bar index of the registered pixel (0..BAR_COUNT-1)
// -----------------------------------------------------------------------------
module vga_bar_counter #(
  parameter int H_ACTIVE  = 640,
  parameter int BAR_COUNT = 8,
  localparam int BAR_W    = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             video_on,
  output logic [BAR_W-1:0] bar_idx
);

  localparam int BAR_LEN = H_ACTIVE / BAR_COUNT;
  localparam int CNT_W   = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAR_LEN - 1);
  localparam logic [BAR_W-1:0] IDX_LAST = BAR_W'(BAR_COUNT - 1);

  logic [CNT_W-1:0] bar_cnt;
  // High when the pixel held in the counters was visible, so the next
  // visible pixel continues the line instead of starting it.
  logic             in_line;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
      in_line <= 1'b0;
    end else if (!video_on) begin
      bar_cnt <= '0;
      bar_idx <= '0;
      in_line <= 1'b0;
    end else if (!in_line) begin
      // First visible pixel of the line sits at column 0 of bar 0.
      bar_cnt <= '0;
      bar_idx <= '0;
      in_line <= 1'b1;
    end else if (bar_cnt == CNT_LAST) begin
      bar_cnt <= '0;
      if (bar_idx != IDX_LAST) begin
        bar_idx <= bar_idx + BAR_W'(1);
      end
    end else begin
      bar_cnt <= bar_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_color_pipe.sv
// -----------------------------------------------------------------------------
// vga_color_pipe
// Two-stage registered VGA colour output stage.
//   Stage 1: registers colour, syncs, video_on and the bar position; detects
//            the active v_sync edge and loads the shadow mode/brightness.
//   Stage 2: selects the colour source (pass / bars / gray / black), expands
//            each channel to OUT_BITS, scales by brightness, blanks outside
//            the visible area and registers the DAC outputs.
// Ports:
//   clk, rst                       : pixel clock, async active-high reset
//   color_in [3*IN_BITS]           : packed {R,G,B}, R in the MSBs
//   h_sync_in, v_sync_in           : syncs from the timing generator
//   video_on_in                    : visible-area flag
//   mode_in [2], bright_in [4]     : requested mode/brightness, latched only
//                                    on the active v_sync edge
//   vga_r/g/b [OUT_BITS]           : colour to the DAC (2-cycle latency)
//   h_sync_out, v_sync_out,
//   video_on_out                   : inputs delayed 2 cycles
//   frame_tick                     : high for the one cycle following the
//                                    edge on which the shadow registers load
// -----------------------------------------------------------------------------
module vga_color_pipe
  import vga_pkg::*;
#(
  parameter int IN_BITS         = 3,
  parameter int OUT_BITS        = 8,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int H_ACTIVE        = 640,
  parameter int BAR_COUNT       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*IN_BITS-1:0] color_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 video_on_in,
  input  logic [1:0]           mode_in,
  input  logic [3:0]           bright_in,
  output logic [OUT_BITS-1:0]  vga_r,
  output logic [OUT_BITS-1:0]  vga_g,
  output logic [OUT_BITS-1:0]  vga_b,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic                 video_on_out,
  output logic                 frame_tick
);

  localparam int   BAR_W     = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
  // Moves bar_idx into the top bits of the 3-bit bar colour code.
  localparam int   K_SHIFT   = 3 - BAR_W;
  localparam int   PROD_W    = OUT_BITS + 5;
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ACT  = ~SYNC_ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Stage 1: input registers, frame-boundary detection, shadow settings
  // ---------------------------------------------------------------------------
  logic [3*IN_BITS-1:0] color_s1;
  logic                 h_sync_s1;
  logic                 v_sync_s1;
  logic                 video_on_s1;
  mode_e                shadow_mode;
  logic [3:0]           shadow_bright;
  logic [BAR_W-1:0]     bar_idx;
  logic                 v_sync_edge;

  assign v_sync_edge = (v_sync_in == SYNC_ACT) && (v_sync_s1 == SYNC_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_s1      <= '0;
      h_sync_s1     <= SYNC_IDLE;
      v_sync_s1     <= SYNC_IDLE;
      video_on_s1   <= 1'b0;
      shadow_mode   <= MODE_PASS;
      shadow_bright <= BRIGHT_UNITY;
      frame_tick    <= 1'b0;
    end else begin
      color_s1    <= color_in;
      h_sync_s1   <= h_sync_in;
      v_sync_s1   <= v_sync_in;
      video_on_s1 <= video_on_in;
      frame_tick  <= v_sync_edge;
      // Settings only change at the frame boundary so a frame never tears.
      // The pixel entering stage 2 on this edge still sees the old values.
      if (v_sync_edge) begin
        shadow_mode   <= mode_e'(mode_in);
        shadow_bright <= bright_in;
      end
    end
  end

  vga_bar_counter #(
    .H_ACTIVE  (H_ACTIVE),
    .BAR_COUNT (BAR_COUNT)
  ) u_bar_counter (
    .clk      (clk),
    .rst      (rst),
    .video_on (video_on_in),
    .bar_idx  (bar_idx)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: source select, expansion, brightness, blanking
  // ---------------------------------------------------------------------------
  logic [IN_BITS-1:0]   in_r;
  logic [IN_BITS-1:0]   in_g;
  logic [IN_BITS-1:0]   in_b;
  logic [2:0]           bar_k;
  logic [IN_BITS+1:0]   gray_sum;
  logic [IN_BITS-1:0]   gray_val;
  logic [4:0]           bright_factor;
  logic [IN_BITS-1:0]   src [3];
  logic [OUT_BITS-1:0]  pix [3];

  assign in_r = color_s1[3*IN_BITS-1 -: IN_BITS];
  assign in_g = color_s1[2*IN_BITS-1 -: IN_BITS];
  assign in_b = color_s1[IN_BITS-1   -: IN_BITS];

  // Bar colour code: bit 2 = red, bit 1 = green, bit 0 = blue.
  assign bar_k = 3'(bar_idx) << K_SHIFT;

  // Luma approximation R/4 + G/2 + B/4; the sum never exceeds 4*max, so the
  // shifted result always fits back into IN_BITS.
  assign gray_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
  assign gray_val = IN_BITS'(gray_sum >> 2);

  assign bright_factor = {1'b0, shadow_bright} + 5'd1;

  // NOTE: every always_comb output gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    src[0] = in_r;
    src[1] = in_g;
    src[2] = in_b;
    case (shadow_mode)
      MODE_PASS: ;
      MODE_BARS: begin
        src[0] = {IN_BITS{bar_k[2]}};
        src[1] = {IN_BITS{bar_k[1]}};
        src[2] = {IN_BITS{bar_k[0]}};
      end
      MODE_GRAY: begin
        src[0] = gray_val;
        src[1] = gray_val;
        src[2] = gray_val;
      end
      MODE_BLACK: begin
        src[0] = '0;
        src[1] = '0;
        src[2] = '0;
      end
      default: ;
    endcase
  end

  // Per-channel expansion and brightness scaling. The product is kept at
  // full width so bright=15 (factor 16) is an exact identity after >> 4.
  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    logic [OUT_BITS-1:0] expanded;
    logic [PROD_W-1:0]   product;

    assign expanded = OUT_BITS'(expand_bits(MAX_IN_W'(src[ch]), IN_BITS, OUT_BITS));
    assign product  = PROD_W'(expanded) * PROD_W'(bright_factor);
    assign pix[ch]  = video_on_s1 ? OUT_BITS'(product >> 4) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
      h_sync_out   <= SYNC_IDLE;
      v_sync_out   <= SYNC_IDLE;
      video_on_out <= 1'b0;
    end else begin
      vga_r        <= pix[0];
      vga_g        <= pix[1];
      vga_b        <= pix[2];
      h_sync_out   <= h_sync_s1;
      v_sync_out   <= v_sync_s1;
      video_on_out <= video_on_s1;
    end
  end

endmodule

// File: tb/tb_vga_color_pipe.sv
// -----------------------------------------------------------------------------
// tb_vga_color_pipe
// Self-checking bench for vga_color_pipe at its default parameters.
// A reference model of the pixel rules runs alongside every driven cycle;
// a vector table and hand-written sequences cover the named corner cases.
// -----------------------------------------------------------------------------
module tb_vga_color_pipe;

  localparam int   IN_BITS   = 3;
  localparam int   OUT_BITS  = 8;
  localparam int   H_ACTIVE  = 640;
  localparam int   BAR_COUNT = 8;
  localparam int   BAR_LEN   = H_ACTIVE / BAR_COUNT;
  localparam int   CH_MAX    = (1 << IN_BITS) - 1;
  localparam logic S_ACT     = 1'b0;
  localparam logic S_IDLE    = 1'b1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3*IN_BITS-1:0] color_in;
  logic                 h_sync_in;
  logic                 v_sync_in;
  logic                 video_on_in;
  logic [1:0]           mode_in;
  logic [3:0]           bright_in;
  logic [OUT_BITS-1:0]  vga_r;
  logic [OUT_BITS-1:0]  vga_g;
  logic [OUT_BITS-1:0]  vga_b;
  logic                 h_sync_out;
  logic                 v_sync_out;
  logic                 video_on_out;
  logic                 frame_tick;

  always #5 clk = ~clk;

  vga_color_pipe #(
    .IN_BITS         (IN_BITS),
    .OUT_BITS        (OUT_BITS),
    .SYNC_ACTIVE_LOW (1'b1),
    .H_ACTIVE        (H_ACTIVE),
    .BAR_COUNT       (BAR_COUNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .color_in     (color_in),
    .h_sync_in    (h_sync_in),
    .v_sync_in    (v_sync_in),
    .video_on_in  (video_on_in),
    .mode_in      (mode_in),
    .bright_in    (bright_in),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .h_sync_out   (h_sync_out),
    .v_sync_out   (v_sync_out),
    .video_on_out (video_on_out),
    .frame_tick   (frame_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pixel position counted as consecutive visible cycles,
  // colour rules applied with integer arithmetic.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [8:0] color;
    logic       hs;
    logic       vs;
    logic       von;
    int         col;
  } pix_t;

  pix_t        prev;
  int          m_mode;
  int          m_bright;
  logic [23:0] last_rgb;
  int          ft_count;

  function automatic int m_expand(input int c);
    int rep  = 0;
    int bits = 0;
    while (bits < OUT_BITS) begin
      rep  = (rep << IN_BITS) | c;
      bits += IN_BITS;
    end
    return rep >> (bits - OUT_BITS);
  endfunction

  function automatic logic [23:0] m_pixel(input pix_t p, input int mode, input int br);
    int ch [3];
    int bar;
    int k;
    int gray;
    if (!p.von) return 24'h0;
    ch[0] = int'(p.color[8:6]);
    ch[1] = int'(p.color[5:3]);
    ch[2] = int'(p.color[2:0]);
    case (mode)
      1: begin
        bar = p.col / BAR_LEN;
        if (bar > BAR_COUNT - 1) bar = BAR_COUNT - 1;
        k = bar * 8 / BAR_COUNT;
        ch[0] = (k & 4) != 0 ? CH_MAX : 0;
        ch[1] = (k & 2) != 0 ? CH_MAX : 0;
        ch[2] = (k & 1) != 0 ? CH_MAX : 0;
      end
      2: begin
        gray = (ch[0] + 2 * ch[1] + ch[2]) / 4;
        ch[0] = gray;
        ch[1] = gray;
        ch[2] = gray;
      end
      3: begin
        ch[0] = 0;
        ch[1] = 0;
        ch[2] = 0;
      end
      default: ;
    endcase
    for (int i = 0; i < 3; i++) ch[i] = m_expand(ch[i]) * (br + 1) / 16;
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  task automatic model_reset();
    prev.color = '0;
    prev.hs    = S_IDLE;
    prev.vs    = S_IDLE;
    prev.von   = 1'b0;
    prev.col   = 0;
    m_mode     = 0;
    m_bright   = 15;
  endtask

  // Drives one pixel clock. After the edge the outputs show the previous
  // pixel; the model predicts it with the shadow values in force before
  // this edge, then applies any frame-boundary load caused by this edge.
  task automatic step(input logic [8:0] c, input logic hs, input logic vs,
                      input logic von, input logic [1:0] m, input logic [3:0] b);
    pix_t        cur;
    logic        edge_d;
    logic [27:0] exp_v;
    logic [27:0] act_v;
    color_in    = c;
    h_sync_in   = hs;
    v_sync_in   = vs;
    video_on_in = von;
    mode_in     = m;
    bright_in   = b;
    @(posedge clk);
    #1;
    edge_d = (vs == S_ACT) && (prev.vs == S_IDLE);
    exp_v  = {m_pixel(prev, m_mode, m_bright), prev.hs, prev.vs, prev.von, edge_d};
    act_v  = {vga_r, vga_g, vga_b, h_sync_out, v_sync_out, video_on_out, frame_tick};
    check("model", 32'(act_v), 32'(exp_v));
    last_rgb = {vga_r, vga_g, vga_b};
    ft_count += int'(frame_tick);
    if (edge_d) begin
      m_mode   = int'(m);
      m_bright = int'(b);
    end
    cur.color = c;
    cur.hs    = hs;
    cur.vs    = vs;
    cur.von   = von;
    cur.col   = von ? (prev.von ? prev.col + 1 : 0) : 0;
    prev      = cur;
  endtask

  // One v_sync pulse: the edge cycle offers (m,b); the following active
  // cycle offers different values that must be ignored.
  task automatic vpulse(input logic [1:0] m, input logic [3:0] b);
    ft_count = 0;
    step(9'h0, S_IDLE, S_ACT, 1'b0, m, b);
    step(9'h0, S_IDLE, S_ACT, 1'b0, ~m, ~b);
    step(9'h0, S_IDLE, S_IDLE, 1'b0, ~m, ~b);
    check("frame_tick_pulses", 32'(ft_count), 32'd1);
  endtask

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [3:0] bright;
    logic [8:0] color;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t        vecs [9];
  logic [23:0] cap  [H_ACTIVE];

  initial begin
    vecs[0] = '{"pass_expand",   2'd0, 4'd15, 9'b111_011_000, 24'hFF6D00};
    vecs[1] = '{"pass_white",    2'd0, 4'd15, 9'h1FF,         24'hFFFFFF};
    vecs[2] = '{"pass_mixed",    2'd0, 4'd15, 9'b001_010_100, 24'h244992};
    vecs[3] = '{"gray_731",      2'd2, 4'd15, 9'b111_011_001, 24'h6D6D6D};
    vecs[4] = '{"gray_white",    2'd2, 4'd15, 9'h1FF,         24'hFFFFFF};
    vecs[5] = '{"bright_7",      2'd0, 4'd7,  9'b111_000_000, 24'h7F0000};
    vecs[6] = '{"bright_0",      2'd0, 4'd0,  9'b111_000_000, 24'h0F0000};
    vecs[7] = '{"black_mode",    2'd3, 4'd15, 9'h1FF,         24'h000000};
    vecs[8] = '{"bars_pixel0",   2'd1, 4'd15, 9'h1FF,         24'h000000};

    // Power-on reset.
    rst = 1'b1;
    color_in = '0; h_sync_in = S_IDLE; v_sync_in = S_IDLE; video_on_in = 1'b0;
    mode_in = 2'd0; bright_in = 4'd15;
    model_reset();
    ft_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({vga_r, vga_g, vga_b, h_sync_out, v_sync_out, video_on_out, frame_tick}),
          32'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;

    // Table: latch mode/brightness, then present one visible pixel while
    // mode_in/bright_in wander.
    foreach (vecs[i]) begin
      vpulse(vecs[i].mode, vecs[i].bright);
      step(vecs[i].color, S_IDLE, S_IDLE, 1'b1, ~vecs[i].mode, ~vecs[i].bright);
      step(vecs[i].color, S_IDLE, S_IDLE, 1'b1, ~vecs[i].mode, ~vecs[i].bright);
      check(vecs[i].name, 32'(last_rgb), 32'(vecs[i].exp_rgb));
      step(9'h0, S_IDLE, S_IDLE, 1'b0, ~vecs[i].mode, ~vecs[i].bright);
    end

    // Blanking and the 2-cycle sync delay.
    step(9'h1FF, S_ACT, S_IDLE, 1'b0, 2'd0, 4'd15);
    check("hsync_still_idle", 32'(h_sync_out), 32'(S_IDLE));
    step(9'h1FF, S_IDLE, S_IDLE, 1'b0, 2'd0, 4'd15);
    check("hsync_delayed", 32'(h_sync_out), 32'(S_ACT));
    check("blank_rgb", 32'(last_rgb), 32'h0);

    // Pass mode latched; mode_in=1 mid-frame has no effect.
    vpulse(2'd0, 4'd15);
    step(9'h1FF, S_IDLE, S_IDLE, 1'b1, 2'd1, 4'd3);
    step(9'h1FF, S_IDLE, S_IDLE, 1'b1, 2'd1, 4'd3);
    check("midframe_ignored", 32'(last_rgb), 32'hFFFFFF);
    step(9'h0, S_IDLE, S_IDLE, 1'b0, 2'd1, 4'd3);

    // Colour bars across a full line.
    vpulse(2'd1, 4'd15);
    for (int i = 0; i < H_ACTIVE; i++) begin
      step(9'($urandom), S_IDLE, S_IDLE, 1'b1, 2'd0, 4'd15);
      if (i > 0) cap[i-1] = last_rgb;
    end
    step(9'h0, S_IDLE, S_IDLE, 1'b0, 2'd0, 4'd15);
    cap[H_ACTIVE-1] = last_rgb;
    check("bar_px0",   32'(cap[0]),   32'h000000);
    check("bar_px79",  32'(cap[79]),  32'h000000);
    check("bar_px80",  32'(cap[80]),  32'h0000FF);
    check("bar_px320", 32'(cap[320]), 32'hFF0000);
    check("bar_px639", 32'(cap[639]), 32'hFFFFFF);

    // Edge during visible pixels: the pixel already in stage 2 keeps pass.
    vpulse(2'd0, 4'd15);
    step(9'h1FF, S_IDLE, S_IDLE, 1'b1, 2'd0, 4'd15);
    step(9'h1FF, S_IDLE, S_ACT,  1'b1, 2'd3, 4'd15);
    check("edge_old_pixel", 32'(last_rgb), 32'hFFFFFF);
    step(9'h1FF, S_IDLE, S_IDLE, 1'b1, 2'd0, 4'd15);
    check("edge_new_pixel", 32'(last_rgb), 32'h000000);
    step(9'h0, S_IDLE, S_IDLE, 1'b0, 2'd0, 4'd15);

    // Mode and brightness change in the edge cycle itself: both latch.
    step(9'h0, S_IDLE, S_IDLE, 1'b0, 2'd0, 4'd15);
    vpulse(2'd2, 4'd7);
    step(9'b111_011_001, S_IDLE, S_IDLE, 1'b1, 2'd0, 4'd15);
    step(9'b111_011_001, S_IDLE, S_IDLE, 1'b1, 2'd0, 4'd15);
    check("simul_latch", 32'(last_rgb), 32'h363636);

    // Asynchronous reset mid-line.
    #2 rst = 1'b1;
    #1;
    check("reset_midline", 32'({vga_r, vga_g, vga_b, h_sync_out, v_sync_out, video_on_out, frame_tick}),
          32'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(9'b111_011_000, S_IDLE, S_IDLE, 1'b1, 2'd2, 4'd0);
    step(9'b111_011_000, S_IDLE, S_IDLE, 1'b1, 2'd2, 4'd0);
    check("after_reset_pass", 32'(last_rgb), 32'hFF6D00);
    step(9'h0, S_IDLE, S_IDLE, 1'b0, 2'd2, 4'd0);

    // Randomised segments, long visible runs reach bar saturation.
    begin
      logic vs_lvl;
      vs_lvl = S_IDLE;
      for (int seg = 0; seg < 30; seg++) begin
        int  len;
        logic von;
        von = (seg % 2) == 0;
        len = von ? int'($urandom_range(1, 760)) : int'($urandom_range(1, 30));
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 63) == 0) vs_lvl = ~vs_lvl;
          step(9'($urandom), 1'($urandom), vs_lvl, von, 2'($urandom), 4'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
